mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the CPU's single synchronous memory port between two requesters: the CPU control/datapath (MAR/MDR path, port C) and a host/program-loader port (port H). It arbitrates, registers the winning request, sequences one memory access with a configurable read latency, and returns read data with a one-cycle completion pulse. It sits between the requesters and the memory macro.

## Interface
- AW, 8, address width
- DW, 8, data width
- MEM_LAT, 1, memory read latency in cycles (legal 1..4)
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority to port C
- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  reset, synchronous, active-high
- c_req, h_req  in  1  access request; hold high with fields stable until the matching done
- c_we, h_we  in  1  1 = write, 0 = read
- c_addr, h_addr  in  AW  access address
- c_wdata, h_wdata  in  DW  write data
- c_gnt, h_gnt  out  1  port owns the memory (ISSUE through DONE)
- c_done, h_done  out  1  one-cycle completion pulse
- c_rdata, h_rdata  out  DW  read data, valid from the done cycle, held until the next read completes on that port
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: requests sampled only here. With no request, stay. With a request, select a winner, latch its we/addr/wdata and the owner bit, set gnt, and go to ISSUE.
- Selection with one request: that port. With both requests, PRIO_MODE=0 picks the port that did not own the previous access; PRIO_MODE=1 always picks C.
- last-owner register resets to H, so C wins the first tie.
- ISSUE (1 cycle): mem_en=1, mem_we=latched we, mem_addr/mem_wdata from latched registers. Load wait counter with MEM_LAT-1. Go to WAIT.
- WAIT: stays MEM_LAT cycles, with the counter decrementing to 0. On the final WAIT cycle, a read captures mem_rdata into the owner's rdata register. A write leaves rdata unchanged. Go to DONE.
- DONE (1 cycle): owner's done=1 and gnt still 1. Update the last-owner register. Go to IDLE unconditionally.
- The requester must drop req in the done cycle. A req still high in the following IDLE cycle is a new request.
- mem_en and mem_we are 0 in every state except ISSUE. mem_addr and mem_wdata hold their last values outside ISSUE.
- The non-owner's gnt and done stay 0 throughout. Its pending req is ignored until IDLE.
- Starvation bound in round-robin mode: a held request waits for at most one other access.
- Requests arriving during ISSUE, WAIT or DONE do not alter the access in flight.

## Timing
- Reset values: state IDLE; c_gnt, h_gnt, c_done, h_done, mem_en, mem_we, busy = 0; mem_addr, mem_wdata, c_rdata, h_rdata = 0; last-owner = H; counter = 0.
- Rst has priority over all transitions. Reset during ISSUE, WAIT or DONE aborts the access with no done pulse and no rdata update, and all outputs take their reset values at that edge.
- req high in cycle 0 (IDLE) gives ISSUE in cycle 1, WAIT in cycles 2..1+MEM_LAT, and DONE in cycle 2+MEM_LAT.
- Latency from req to done is 2+MEM_LAT cycles. Back-to-back throughput is one access per 3+MEM_LAT cycles.
- gnt is high from cycle 1 through cycle 2+MEM_LAT inclusive. busy has the same timing.
- All outputs are registered or decoded from registered state only. There is no combinational path from req to any output.

## Test plan
- Single C read, MEM_LAT=1, addr 0x10 holds 0x5A: c_req in cycle 0 -> mem_en=1, mem_addr=0x10 in cycle 1; c_done=1 and c_rdata=0x5A in cycle 3; h_* signals stay 0.
- H write 0xA5 to 0x20, then C read of 0x20: mem_we=1 only in H's ISSUE cycle, h_rdata unchanged; C read returns 0xA5.
- Both req held continuously, PRIO_MODE=0: grants alternate C, H, C, H, with each done exactly 4 cycles apart.
- Both req held, PRIO_MODE=1: C receives every grant and h_gnt never rises.
- MEM_LAT=3, C read: done in cycle 5, and mem_rdata is captured in cycle 4 only (the bench changes mem_rdata in other cycles to check this).
- Rst asserted in the WAIT cycle of an H read: no h_done, h_rdata keeps its prior value, all outputs are 0 on the next cycle, and the first tie after reset is won by C.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request, completion and memory-side signals of the two-port memory arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          c_req, c_we, c_gnt, c_done;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic          h_req, h_we, h_gnt, h_done;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata, h_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, h_req, h_we, h_addr, h_wdata, mem_rdata,
        output c_gnt, c_done, c_rdata, h_gnt, h_done, h_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, h_req, h_we, h_addr, h_wdata, mem_rdata,
        input  c_gnt, c_done, c_rdata, h_gnt, h_done, h_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for a single synchronous memory port: picks C or H in IDLE,
// runs one ISSUE/WAIT/DONE access and returns read data with a done pulse.
module mem_port_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MEM_LAT   = 1,
    parameter int PRIO_MODE = 0
) (
    input logic             Clk,
    input logic             Rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state;
    logic          owner;      // 0 = C, 1 = H
    logic          lastOwner;
    logic          weReg;
    logic [1:0]    cnt;
    logic          cGnt, hGnt, cDone, hDone, memEn, memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata, cRdata, hRdata;
    logic          pickH;

    // H wins when alone, or on a tie in round-robin mode when C owned the last access
    assign pickH = bus.h_req && (!bus.c_req || (PRIO_MODE == 0 && !lastOwner));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            lastOwner <= 1'b1;
            weReg     <= 1'b0;
            cnt       <= '0;
            cGnt      <= 1'b0;
            hGnt      <= 1'b0;
            cDone     <= 1'b0;
            hDone     <= 1'b0;
            memEn     <= 1'b0;
            memWe     <= 1'b0;
            memAddr   <= '0;
            memWdata  <= '0;
            cRdata    <= '0;
            hRdata    <= '0;
        end else begin
            case (state)
                IDLE: if (bus.c_req || bus.h_req) begin
                    owner    <= pickH;
                    weReg    <= pickH ? bus.h_we    : bus.c_we;
                    memWe    <= pickH ? bus.h_we    : bus.c_we;
                    memAddr  <= pickH ? bus.h_addr  : bus.c_addr;
                    memWdata <= pickH ? bus.h_wdata : bus.c_wdata;
                    memEn    <= 1'b1;
                    cGnt     <= !pickH;
                    hGnt     <= pickH;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    memEn <= 1'b0;
                    memWe <= 1'b0;
                    cnt   <= 2'(MEM_LAT - 1);
                    state <= WAIT;
                end
                WAIT: if (cnt == 2'd0) begin
                    // mem_rdata is valid exactly in the last WAIT cycle
                    if (!weReg) begin
                        if (owner) hRdata <= bus.mem_rdata;
                        else       cRdata <= bus.mem_rdata;
                    end
                    cDone <= !owner;
                    hDone <= owner;
                    state <= DONE;
                end else begin
                    cnt <= cnt - 2'd1;
                end
                DONE: begin
                    cDone     <= 1'b0;
                    hDone     <= 1'b0;
                    cGnt      <= 1'b0;
                    hGnt      <= 1'b0;
                    lastOwner <= owner;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.c_gnt     = cGnt;
    assign bus.h_gnt     = hGnt;
    assign bus.c_done    = cDone;
    assign bus.h_done    = hDone;
    assign bus.c_rdata   = cRdata;
    assign bus.h_rdata   = hRdata;
    assign bus.mem_en    = memEn;
    assign bus.mem_we    = memWe;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign bus.busy      = (state != IDLE);
endmodule
